// File: rtl/rbcp_iic_pkg.sv
// Shared types and constants for the RBCP-to-IIC bridge.
package rbcp_iic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_INIT,
    REQ,
    XFER,
    ACK
  } state_t;

  // Read data returned to RBCP when an access fails
  localparam logic [7:0] RD_FAIL = 8'hFF;

  // Field positions inside RBCP_ADDR
  localparam int DAD_MSB = 14;
  localparam int DAD_LSB = 8;
  localparam int ADR_MSB = 7;
  localparam int ADR_LSB = 0;

endpackage

// File: rtl/rbcp_iic_timeout.sv
// Per-access watchdog: clearable up-counter with a single-cycle expire flag.
module rbcp_iic_timeout #(
  parameter logic [23:0] TIMEOUT = 24'd2_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [23:0] r_cnt;

  // Expire on the cycle the count would reach TIMEOUT, so the caller's
  // next-state decision lands exactly TIMEOUT cycles after the count started.
  assign o_expire = i_en && (r_cnt == TIMEOUT - 24'd1);

  // Count while enabled; hold at the limit instead of wrapping
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                r_cnt <= '0;
    else if (i_clr)              r_cnt <= '0;
    else if (i_en && !o_expire)  r_cnt <= r_cnt + 24'd1;
  end

endmodule

// File: rtl/rbcp_iic_bridge.sv
// Maps one RBCP address window onto a single-byte IIC ch0 request; every
// access is serialised, held off during IIC init, and bounded by a timeout.
module rbcp_iic_bridge
  import rbcp_iic_pkg::*;
#(
  parameter logic [15:0] WIN_BASE = 16'h1000,
  parameter logic [23:0] TIMEOUT  = 24'd2_000_000
) (
  input  logic        CLK,
  input  logic        SYS_RSTn,
  input  logic [31:0] RBCP_ADDR,
  input  logic [7:0]  RBCP_WD,
  input  logic        RBCP_WE,
  input  logic        RBCP_RE,
  output logic        RBCP_ACK,
  output logic [7:0]  RBCP_RD,
  input  logic        IIC_INIT_IN,
  output logic        IIC_REQ_OUT,
  output logic [7:0]  IIC_NUM_OUT,
  output logic [6:0]  IIC_DAD_OUT,
  output logic [7:0]  IIC_ADR_OUT,
  output logic        IIC_RNW_OUT,
  output logic [7:0]  IIC_WDT_OUT,
  input  logic        IIC_RAK_IN,
  input  logic        IIC_WAE_IN,
  input  logic        IIC_BSY_IN,
  input  logic [7:0]  IIC_RDT_IN,
  input  logic        IIC_RVL_IN,
  input  logic        IIC_ERR_IN,
  output logic        BUSY_OUT,
  output logic [7:0]  ERR_CNT_OUT
);

  state_t      r_state, w_next;
  logic        w_hit, w_fail, w_exp, w_tmr_clr, w_tmr_en;
  logic        r_done;
  logic [7:0]  r_rd;
  logic        r_req, r_ack, r_busy, r_rnw;
  logic [7:0]  r_rd_out, r_err_cnt, r_adr, r_wdt;
  logic [6:0]  r_dad;

  assign w_hit     = (RBCP_WE | RBCP_RE) && (RBCP_ADDR[31:16] == WIN_BASE) && !RBCP_ADDR[15];
  assign w_tmr_clr = (r_state == IDLE);
  assign w_tmr_en  = (r_state == WAIT_INIT) || (r_state == REQ) || (r_state == XFER);

  rbcp_iic_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
    .i_clk    (CLK),
    .i_rst_n  (SYS_RSTn),
    .i_clr    (w_tmr_clr),
    .i_en     (w_tmr_en),
    .o_expire (w_exp)
  );

  // State register
  always_ff @(posedge CLK or negedge SYS_RSTn) begin
    if (!SYS_RSTn) r_state <= IDLE;
    else           r_state <= w_next;
  end

  // Next state; any error or timeout short-circuits to ACK with FAIL status
  always_comb begin
    w_next = r_state;
    w_fail = 1'b0;
    case (r_state)
      IDLE:      if (w_hit) w_next = IIC_INIT_IN ? WAIT_INIT : REQ;
      WAIT_INIT: if (w_exp) w_fail = 1'b1;
                 else if (!IIC_INIT_IN) w_next = REQ;
      REQ:       if (IIC_ERR_IN || w_exp) w_fail = 1'b1;
                 else if (IIC_RAK_IN) w_next = XFER;
      XFER:      if (IIC_ERR_IN || w_exp) w_fail = 1'b1;
                 else if (r_done && !IIC_BSY_IN) w_next = ACK;
      ACK:       w_next = IDLE;
      default:   w_next = IDLE;
    endcase
    if (w_fail) w_next = ACK;
  end

  // Latch the request fields on a hit; they stay stable for the whole access
  always_ff @(posedge CLK or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      r_dad <= '0;
      r_adr <= '0;
      r_wdt <= '0;
      r_rnw <= 1'b0;
    end else if (r_state == IDLE && w_hit) begin
      r_dad <= RBCP_ADDR[DAD_MSB:DAD_LSB];
      r_adr <= RBCP_ADDR[ADR_MSB:ADR_LSB];
      r_wdt <= RBCP_WD;
      r_rnw <= ~RBCP_WE;
    end
  end

  // Transfer completion flag and read data capture
  always_ff @(posedge CLK or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      r_done <= 1'b0;
      r_rd   <= '0;
    end else if (w_fail) begin
      r_rd   <= RD_FAIL;
    end else if (r_state == IDLE && w_hit) begin
      r_done <= 1'b0;
      r_rd   <= '0;
    end else if (r_state == XFER) begin
      if (!r_rnw && IIC_WAE_IN) r_done <= 1'b1;
      if (r_rnw && IIC_RVL_IN) begin
        r_rd   <= IIC_RDT_IN;
        r_done <= 1'b1;
      end
    end
  end

  // Registered outputs decoded from the next state
  always_ff @(posedge CLK or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      r_req    <= 1'b0;
      r_ack    <= 1'b0;
      r_busy   <= 1'b0;
      r_rd_out <= '0;
    end else begin
      r_req    <= (w_next == REQ);
      r_ack    <= (w_next == ACK);
      r_busy   <= (w_next != IDLE);
      r_rd_out <= (w_next != ACK) ? 8'h00 :
                  w_fail          ? RD_FAIL :
                  r_rnw           ? r_rd : 8'h00;
    end
  end

  // Saturating failed-access counter
  always_ff @(posedge CLK or negedge SYS_RSTn) begin
    if (!SYS_RSTn)                          r_err_cnt <= '0;
    else if (w_fail && r_err_cnt != 8'hFF)  r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign RBCP_ACK    = r_ack;
  assign RBCP_RD     = r_rd_out;
  assign IIC_REQ_OUT = r_req;
  assign IIC_NUM_OUT = 8'h00;
  assign IIC_DAD_OUT = r_dad;
  assign IIC_ADR_OUT = r_adr;
  assign IIC_RNW_OUT = r_rnw;
  assign IIC_WDT_OUT = r_wdt;
  assign BUSY_OUT    = r_busy;
  assign ERR_CNT_OUT = r_err_cnt;

endmodule
